// File: rtl/timer_bank_if.sv
// Register-port bundle for timer_bank: one write strobe, {channel, reg} address,
// write data and the combinational read-back of the addressed register.
interface timer_bank_if #(
  parameter int NUM_CHANNELS = 4
);
  logic                              write;
  logic [$clog2(NUM_CHANNELS)+1:0]   addr;
  logic [31:0]                       data_in;
  logic [31:0]                       data_out;

  modport master (output write, addr, data_in, input data_out);
  modport slave  (input write, addr, data_in, output data_out);
endinterface

// File: rtl/timer_bank.sv
// Multi-channel down-counting timer bank: per-channel prescaler, one-shot/periodic, sticky pending, irq.
// Optional TIMER_OVERRUN_EN adds a saturating overrun counter in STATUS[15:8].
module timer_chan #(
  parameter int CW   = 32,
  parameter int MAXP = 7,
  parameter int PW   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_wr,
  input  logic        ctrl_wr,
  input  logic        stat_wr,
  input  logic [31:0] wdata,
  input  logic [1:0]  rsel,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef struct packed {
    logic [3:0] shift;
    logic       irq_en;
    logic       periodic;
    logic       enable;
  } ctrl_t;

  ctrl_t         ctrl;
  logic [CW-1:0] load, count;
  logic [PW-1:0] pre, pmask;
  logic          pending, zl_arm;
  logic          run, tick, expire, clr;
  logic [3:0]    shift_in;
  logic [7:0]    ovr_rd;
  logic          unused_wdata;

  assign unused_wdata = ^wdata;
  assign shift_in = (wdata[7:4] > 4'(MAXP)) ? 4'(MAXP) : wdata[7:4];
  assign pmask    = PW'((32'd1 << ctrl.shift) - 32'd1);
  // A LOAD write owns the cycle: no counting and no expiry alongside it.
  assign run      = ctrl.enable && (count != '0) && !load_wr;
  // >= rather than == so a P decrease below the current prescaler ticks right away.
  assign tick     = run && (pre >= pmask);
  assign expire   = (tick && count == CW'(1)) || (zl_arm && !load_wr);
  assign clr      = stat_wr && wdata[0];
  assign irq      = pending && ctrl.irq_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl    <= '0;
      load    <= '0;
      count   <= '0;
      pre     <= '0;
      pending <= 1'b0;
      zl_arm  <= 1'b0;
    end else begin
      zl_arm <= 1'b0;
      if (ctrl_wr) ctrl <= {shift_in, wdata[2], wdata[1], wdata[0]};
      if (load_wr) begin
        load   <= wdata[CW-1:0];
        count  <= wdata[CW-1:0];
        pre    <= '0;
        zl_arm <= ctrl.enable && (wdata[CW-1:0] == '0);
      end else if (run) begin
        pre <= tick ? '0 : pre + PW'(1);
        if (tick) count <= (count == CW'(1)) ? (ctrl.periodic ? load : '0) : count - CW'(1);
      end
      if (expire)   pending <= 1'b1;
      else if (clr) pending <= 1'b0;
    end
  end

`ifdef TIMER_OVERRUN_EN
  logic [7:0] ovr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   ovr <= '0;
    else if (clr)                               ovr <= (expire && pending) ? 8'd1 : 8'd0;
    else if (expire && pending && ovr != 8'hFF) ovr <= ovr + 8'd1;
  end
  assign ovr_rd = ovr;
`else
  assign ovr_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (rsel)
      2'd0:    rdata[CW-1:0] = load;
      2'd1:    rdata[7:0]    = {ctrl.shift, 1'b0, ctrl.irq_en, ctrl.periodic, ctrl.enable};
      2'd2:    rdata[CW-1:0] = count;
      default: rdata[15:0]   = {ovr_rd, 7'd0, pending};
    endcase
  end
endmodule

module timer_bank #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 32,
  parameter int MAX_PRESCALE  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  timer_bank_if.slave             bus,
  output logic [NUM_CHANNELS-1:0] irq
);
  localparam int PW = (MAX_PRESCALE > 0) ? MAX_PRESCALE : 1;

  logic [NUM_CHANNELS-1:0][31:0] rdata;
  logic [31:0]                   ch_idx;
  logic [1:0]                    rsel;

  assign ch_idx = 32'(bus.addr >> 2);
  assign rsel   = bus.addr[1:0];

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic sel;
    assign sel = bus.write && (ch_idx == 32'(i));
    timer_chan #(.CW(COUNTER_WIDTH), .MAXP(MAX_PRESCALE), .PW(PW)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .load_wr(sel && rsel == 2'd0),
      .ctrl_wr(sel && rsel == 2'd1),
      .stat_wr(sel && rsel == 2'd3),
      .wdata  (bus.data_in),
      .rsel   (rsel),
      .rdata  (rdata[i]),
      .irq    (irq[i])
    );
  end

  // Channel indices past NUM_CHANNELS match nothing and read as zero.
  always_comb begin
    bus.data_out = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (ch_idx == 32'(i)) bus.data_out = rdata[i];
  end
endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: register vector table, directed corner sequences,
// and randomized expiry timing against arithmetic expectations (N * 2^P cycles).
module tb_timer_bank;
  localparam int NCH  = 3;
  localparam int CW   = 16;
  localparam int MAXP = 7;
`ifdef TIMER_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] irq;
  int             cyc = 0;
  int             ntests = 0;
  int             nfail = 0;

  timer_bank_if #(.NUM_CHANNELS(NCH)) bus();
  timer_bank #(.NUM_CHANNELS(NCH), .COUNTER_WIDTH(CW), .MAX_PRESCALE(MAXP)) dut (
    .clk(clk), .rst(rst), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] din;
    bit          chk;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [3:0] A(input int ch, input int r);
    return 4'(ch * 4 + r);
  endfunction
  function automatic void tW(input logic [3:0] a, input logic [31:0] d);
    vec_t v; v.wr = 1; v.addr = a; v.din = d; v.chk = 0; v.exp = 0; tbl.push_back(v);
  endfunction
  function automatic void tR(input logic [3:0] a, input logic [31:0] e);
    vec_t v; v.wr = 0; v.addr = a; v.din = 0; v.chk = 1; v.exp = e; tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a negedge; the write lands on the following posedge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.write = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.addr = a; #1; d = bus.data_out;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input int ch, input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (irq[ch]) begin when = cyc; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); bus.write = 1'b0; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int k, when, T, c, n, p;
    int nn[NCH], pp[NCH], wk[NCH], rise[NCH];

    bus.write = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    check("reset_irq", 32'(irq), 0);
    rst = 1'b1;

    // Register-access vectors
    tR(A(0,0), 0); tR(A(2,1), 0);
    tW(A(1,0), 32'h0001_2345); tR(A(1,0), 32'h2345); tR(A(1,2), 32'h2345);
    tW(A(1,2), 32'h55);        tR(A(1,2), 32'h2345);
    tW(A(1,1), 32'hFFFF_FFF6); tR(A(1,1), 32'h76);   tR(A(0,0), 0);
    tW(A(3,0), 32'hABCD);      tR(A(3,0), 0);        tR(A(3,3), 0); tR(A(2,0), 0);
    tW(A(0,1), 32'h1);         tW(A(0,0), 3);
    tR(A(0,2), 3); tR(A(0,2), 2); tR(A(0,3), 0); tR(A(0,3), 1); tR(A(0,2), 0); tR(A(0,2), 0);
    tW(A(0,3), 0); tR(A(0,3), 1); tW(A(0,3), 1); tR(A(0,3), 0);
    tW(A(0,0), 0); tR(A(0,3), 0); tR(A(0,3), 1);
    tW(A(0,3), 1); tW(A(0,1), 0); tW(A(0,0), 0); tR(A(0,3), 0); tR(A(0,3), 0);
    for (int i = 0; i < tbl.size(); i++) begin
      bus.write = tbl[i].wr; bus.addr = tbl[i].addr; bus.data_in = tbl[i].din;
      #1;
      if (tbl[i].chk) check($sformatf("vec%0d", i), bus.data_out, tbl[i].exp);
      @(negedge clk);
    end
    bus.write = 1'b0;

    // One-shot latency for each prescale, random N
    for (int t = 0; t < 10; t++) begin
      do_reset();
      c = int'($urandom_range(0, NCH-1));
      if (t < 8) begin p = t; n = int'($urandom_range(2, 2000 >> p)); end
      else if (t == 8) begin p = 3; n = 0; end
      else begin p = 7; n = 1; end
      T = (n == 0) ? 1 : (n << p);
      wr(A(c,1), 32'h5 | 32'(p << 4));
      wr(A(c,0), 32'(n));
      k = cyc;
      wait_irq(c, T + 20, when);
      check($sformatf("oneshot_c%0d_p%0d_n%0d", c, p, n), 32'(when - k), 32'(T));
    end

    // Periodic LOAD=5, P=1: pulses every 10 cycles, cleared after each
    do_reset();
    wr(A(0,0), 5); wr(A(0,1), 32'h17);
    k = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_irq(0, 30, when);
      check($sformatf("periodic_pulse%0d", i), 32'(when - k), 32'(10 * (i + 1)));
      wr(A(0,3), 1);
      check($sformatf("periodic_cleared%0d", i), 32'(irq[0]), 0);
    end

    // Clear on the exact expiry edge: pending survives
    do_reset();
    wr(A(0,0), 4); wr(A(0,1), 32'h3);
    idle(7);
    wr(A(0,3), 1);
    rd(A(0,3), d);
    check("clr_on_expiry_pend", 32'(d[0]), 1);
    check("clr_on_expiry_ovr", 32'(d[15:8]), OVR ? 1 : 0);
    check("status_hi_zero", 32'(d[31:16]), 0);
    wr(A(0,3), 1);
    rd(A(0,3), d);
    check("clr_off_expiry", 32'(d[0]), 0);

    // LOAD write on the expiry tick: new value, no expiry
    do_reset();
    wr(A(0,0), 3); wr(A(0,1), 32'h5);
    k = cyc;
    idle(2);
    wr(A(0,0), 9);
    rd(A(0,2), d); check("load_on_tick_count", d, 9);
    rd(A(0,3), d); check("load_on_tick_pend", 32'(d[0]), 0);
    wait_irq(0, 30, when);
    check("load_on_tick_rise", 32'(when - k), 12);

    // Disable at COUNT=7 for 20 cycles
    do_reset();
    wr(A(0,0), 10); wr(A(0,1), 32'h5);
    k = cyc;
    idle(2);
    wr(A(0,1), 32'h4);
    rd(A(0,2), d); check("frozen_count_a", d, 7);
    idle(19);
    rd(A(0,2), d); check("frozen_count_b", d, 7);
    wr(A(0,1), 32'h5);
    wait_irq(0, 40, when);
    check("disable_delay", 32'(when - k), 30);
    wr(A(0,1), 32'h1);
    check("irq_masked", 32'(irq[0]), 0);
    rd(A(0,3), d); check("masked_pending", 32'(d[0]), 1);

    // All channels concurrently
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < NCH; i++) begin
        nn[i] = int'($urandom_range(0, 80)); pp[i] = int'($urandom_range(0, 3)); rise[i] = -1;
        wr(A(i,1), 32'h5 | 32'(pp[i] << 4));
      end
      fork
        for (int i = 0; i < NCH; i++) begin wr(A(i,0), 32'(nn[i])); wk[i] = cyc; end
        for (int j = 0; j < 800; j++) begin
          @(negedge clk);
          for (int i = 0; i < NCH; i++) if (rise[i] < 0 && irq[i]) rise[i] = cyc;
        end
      join
      for (int i = 0; i < NCH; i++)
        check($sformatf("concurrent_r%0d_c%0d", r, i), 32'(rise[i] - wk[i]),
              32'((nn[i] == 0) ? 1 : (nn[i] << pp[i])));
    end

    // Asynchronous reset mid-count
    do_reset();
    wr(A(0,1), 32'h5); wr(A(0,0), 2);
    wr(A(1,1), 32'h35); wr(A(1,0), 500);
    idle(5);
    check("pre_reset_irq", 32'(irq[0]), 1);
    bus.addr = A(1,2);
    #3 rst = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq), 0);
    check("async_reset_count", bus.data_out, 0);
    #3 rst = 1'b1;
    idle(20);
    rd(A(1,2), d); check("post_reset_count", d, 0);
    rd(A(1,1), d); check("post_reset_ctrl", d, 0);
    check("post_reset_irq", 32'(irq), 0);

    // Periodic LOAD=1 without clearing: overrun counter
    do_reset();
    wr(A(2,0), 1); wr(A(2,1), 32'h7);
    idle(10);
    rd(A(2,3), d);
    check("ovr_after10", 32'(d[15:8]), OVR ? 9 : 0);
    check("ovr_pend", 32'(d[0]), 1);
    wr(A(2,3), 1);
    rd(A(2,3), d);
    check("ovr_clr_same_cycle", 32'(d[15:0]), OVR ? 32'h0101 : 32'h0001);
    idle(300);
    rd(A(2,3), d);
    check("ovr_saturate", 32'(d[15:8]), OVR ? 255 : 0);
    check("ovr_irq", 32'(irq[2]), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
